spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50, meaning clk cycles per SCK half-period (100 MHz clk gives 1 MHz SCK).
REQ-002 SHALL provide parameter FRAME_BITS, default 48, meaning bits per chip-select frame.
REQ-003 SHALL provide parameter GAP_CYCLES, default 100, meaning minimum clk cycles cs_n stays high between frames.
REQ-004 SHALL provide port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL provide port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port start  input  1  request a frame; sampled only when busy=0.
REQ-007 SHALL provide port tx_data  input  FRAME_BITS  frame to transmit, MSB first.
REQ-008 SHALL provide port busy  output  1  high from the cycle after start is accepted through the end of the gap.
REQ-009 SHALL provide port done  output  1  one-cycle pulse when rx_data is updated.
REQ-010 SHALL provide port rx_data  output  FRAME_BITS  last complete received frame.
REQ-011 SHALL provide port spi_sck  output  1  SPI clock, idle low (mode 0).
REQ-012 SHALL provide port spi_mosi  output  1  serial data to the slave shift register din.
REQ-013 SHALL provide port spi_miso  input  1  serial data from the slave shift register dout.
REQ-014 SHALL provide port spi_cs_n  output  1  frame select, active-low.

Function
REQ-015 SHALL implement the states IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-016 In IDLE with start=1, the block SHALL latch tx_data into the shift register and enter SETUP on that edge (cycle 0).
REQ-017 On entering SETUP (cycle 1), the block SHALL assert cs_n=0, busy=1 and mosi=tx_data[FRAME_BITS-1], with sck=0.
REQ-018 A half-period counter SHALL count CLK_DIV cycles in each of SETUP, HIGH, LOW and HOLD, then advance the state.
REQ-019 On the SETUP->HIGH and LOW->HIGH edges, the block SHALL set sck=1 and shift spi_miso into the LSB of the receive register (sample on rising SCK).
REQ-020 On the HIGH->LOW edge, the block SHALL set sck=0 and present the next tx bit on mosi (change on falling SCK), if bits remain.
REQ-021 The bit counter SHALL count rising edges; after the FRAME_BITS-th HIGH, the block SHALL go to HOLD (sck=0, mosi holds the last bit) instead of LOW.
REQ-022 HOLD->GAP transition: cs_n=1, mosi=0, rx_data loaded from the receive register, and done=1 for exactly one cycle.
REQ-023 With CLK_DIV=50 and FRAME_BITS=48: first sck rise at cycle 51; last fall at cycle 4801; cs_n high and done at cycle 4851.
REQ-024 GAP SHALL last GAP_CYCLES cycles with cs_n=1, sck=0, busy=1, then return to IDLE with busy=0.
REQ-025 start while busy=1 SHALL be ignored, not queued; changes on tx_data after acceptance SHALL have no effect on the frame.
REQ-026 start held high continuously SHALL produce back-to-back frames, each separated by GAP_CYCLES+1 cycles of cs_n=1.
REQ-027 sck SHALL be driven from a register, never gated combinationally from clk.
REQ-028 Elaboration SHALL fail if CLK_DIV<2, FRAME_BITS<1, FRAME_BITS>64 or GAP_CYCLES<1.

Reset
REQ-029 While nreset=0, outputs SHALL be sck=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0, state IDLE, and all counters zero.
REQ-030 nreset asserted mid-frame SHALL force the REQ-029 values immediately, without a done pulse; the partial frame SHALL be discarded.
REQ-031 After nreset deasserts, the first start SHALL be accepted on the first clk edge.

Verification
REQ-032 Loopback (mosi tied to miso) with tx_data=48'hA5A5_0F0F_1234 SHALL give rx_data=48'hA5A5_0F0F_1234 and exactly one done pulse, at cycle 4851.
REQ-033 Timing: each frame SHALL have exactly 48 sck rising edges, each high and low phase 50 cycles, cs_n low throughout, and mosi stable across every rising edge.
REQ-034 A start pulse at cycle 1000 during a frame, plus tx_data changed at cycle 10, SHALL produce no second frame and leave the transmitted bits equal to the originally latched value.
REQ-035 nreset pulsed low at the 20th sck rise SHALL set cs_n=1, sck=0 and busy=0 asynchronously; no done pulse; rx_data stays at its prior value of 0.
REQ-036 start held at 1 with miso=1 SHALL give rx_data=48'hFFFF_FFFF_FFFF after each frame, with cs_n high for 101 cycles between frames.
REQ-037 Against the shiftreg slave driven by spi_sck/mosi/cs_n, the slave regout SHALL equal tx_data after the frame, and rx_data SHALL equal the slave's preloaded contents.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: one chip-select frame of FRAME_BITS bits, MSB first,
// with a registered SCK and a minimum chip-select gap between frames.
module spi_master #(
    parameter int CLK_DIV    = 50,
    parameter int FRAME_BITS = 48,
    parameter int GAP_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n
);

    generate
        if (CLK_DIV < 2 || FRAME_BITS < 1 || FRAME_BITS > 64 || GAP_CYCLES < 1) begin : g_bad_param
            $error("spi_master: illegal CLK_DIV/FRAME_BITS/GAP_CYCLES");
        end
    endgenerate

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cnt_last;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        cnt_last    = (state_q == GAP) ? (cnt_q == GAP_LAST) : (cnt_q == HALF_LAST);
        tx_shift    = tx_q << 1;
        rx_shift    = rx_q << 1;
        rx_shift[0] = spi_miso;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = tx_data;
                    mosi_d  = tx_data[FRAME_BITS-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                if (cnt_last) begin
                    // Rising SCK: sample MISO into the receive register.
                    sck_d   = 1'b1;
                    rx_d    = rx_shift;
                    bit_d   = bit_q + BW'(1);
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    if (bit_q == BITS_LAST) begin
                        state_d = HOLD;
                    end else begin
                        tx_d    = tx_shift;
                        mosi_d  = tx_shift[FRAME_BITS-1];
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_last) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback, late start, mid-frame reset,
// back-to-back frames and a shift-register slave.
module tb_spi_master;

    localparam int CLK_DIV = 50;
    localparam int FB      = 48;
    localparam int GAP     = 100;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [FB-1:0] tx_data = '0;
    logic          busy, done;
    logic [FB-1:0] rx_data;
    logic          spi_sck, spi_mosi, spi_miso, spi_cs_n;

    logic [1:0]    miso_sel = 2'd0;
    logic [FB-1:0] slv;
    logic [FB-1:0] slv_init = '0;
    logic          slv_ld = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [FB-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FB), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .nreset(nreset), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    always @(posedge spi_sck or posedge slv_ld) begin
        if (slv_ld) slv <= slv_init;
        else if (!spi_cs_n) slv <= {slv[FB-2:0], spi_mosi};
    end

    assign spi_miso = (miso_sel == 2'd0) ? spi_mosi :
                      (miso_sel == 2'd1) ? 1'b1 : slv[FB-1];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Collects per-frame timing statistics; starts sampling at frame cycle 1.
    task automatic frame_watch(input bit chg_tx, input bit late_start,
                               output int rises, output int first_rise,
                               output int last_fall, output int bad_phase,
                               output int unstable, output int cs_bad,
                               output int done_cyc, output logic [FB-1:0] bits);
        int run;
        logic p_sck, p_mosi;
        rises = 0; first_rise = 0; last_fall = 0; bad_phase = 0;
        unstable = 0; cs_bad = 0; done_cyc = 0; bits = '0;
        run = 0; p_sck = 1'b0; p_mosi = spi_mosi;
        for (int c = 1; c <= 6000; c++) begin
            if (c > 1) step();
            if (chg_tx && c == 10) tx_data = ~tx_data;
            if (late_start) start = (c == 1000);
            if (done) begin
                done_cyc = c;
                break;
            end
            if (spi_cs_n) cs_bad++;
            if (spi_sck != p_sck) begin
                if (rises > 0 && run != CLK_DIV) bad_phase++;
                if (spi_sck) begin
                    rises++;
                    if (first_rise == 0) first_rise = c;
                    if (spi_mosi !== p_mosi) unstable++;
                    bits = {bits[FB-2:0], spi_mosi};
                end else begin
                    last_fall = c;
                end
                run = 1;
            end else begin
                run++;
            end
            p_sck = spi_sck;
            p_mosi = spi_mosi;
        end
    endtask

    task automatic test_reset;
        repeat (3) step();
        n_cmp++;
        if ({spi_sck, spi_mosi, spi_cs_n, busy, done} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b exp=00100", {spi_sck, spi_mosi, spi_cs_n, busy, done});
        end
        n_cmp++;
        if (rx_data !== '0) begin
            n_bad++;
            $display("FAIL reset_rx got=%h exp=0", rx_data);
        end
        nreset = 1'b1;
        step();
        n_cmp++;
        if ({spi_cs_n, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL idle_after_reset got=%b exp=10", {spi_cs_n, busy});
        end
    endtask

    task automatic test_reset_midframe;
        int rises;
        int dn;
        logic p;
        miso_sel = 2'd0;
        tx_data = 48'h1234_5678_9ABC;
        start = 1'b1;
        step();
        start = 1'b0;
        rises = 0; p = 1'b0; dn = 0;
        for (int c = 0; c < 3000 && rises < 20; c++) begin
            if (spi_sck && !p) rises++;
            p = spi_sck;
            if (rises < 20) step();
        end
        n_cmp++;
        if (rises != 20) begin
            n_bad++;
            $display("FAIL midrst_reach got=%0d exp=20", rises);
        end
        nreset = 1'b0;
        #1;
        n_cmp++;
        if ({spi_cs_n, spi_sck, busy, done, spi_mosi} !== 5'b10000) begin
            n_bad++;
            $display("FAIL midrst_async got=%b exp=10000", {spi_cs_n, spi_sck, busy, done, spi_mosi});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_bad++;
            $display("FAIL midrst_done got=%0d exp=0", dn);
        end
        n_cmp++;
        if (rx_data !== '0) begin
            n_bad++;
            $display("FAIL midrst_rx got=%h exp=0", rx_data);
        end
        start = 1'b1;
        nreset = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({spi_cs_n, busy, spi_mosi} !== {2'b01, tx_data[FB-1]}) begin
            n_bad++;
            $display("FAIL first_start got=%b exp=01%b", {spi_cs_n, busy, spi_mosi}, tx_data[FB-1]);
        end
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        step();
    endtask

    task automatic test_loopback;
        int r, fr, lf, bp, us, cb, dc, g;
        logic [FB-1:0] bits, tx, ex;
        tx = 48'hA5A5_0F0F_1234;
        miso_sel = 2'd0;
        tx_data = tx;
        exp_q.push_back(tx);
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({spi_cs_n, busy, spi_sck, spi_mosi} !== {3'b010, tx[FB-1]}) begin
            n_bad++;
            $display("FAIL setup got=%b exp=010%b", {spi_cs_n, busy, spi_sck, spi_mosi}, tx[FB-1]);
        end
        frame_watch(1'b0, 1'b0, r, fr, lf, bp, us, cb, dc, bits);
        n_cmp++;
        if (r != FB) begin n_bad++; $display("FAIL lb_rises got=%0d exp=%0d", r, FB); end
        n_cmp++;
        if (fr != 51) begin n_bad++; $display("FAIL lb_first_rise got=%0d exp=51", fr); end
        n_cmp++;
        if (lf != 4801) begin n_bad++; $display("FAIL lb_last_fall got=%0d exp=4801", lf); end
        n_cmp++;
        if (bp != 0) begin n_bad++; $display("FAIL lb_phase got=%0d exp=0", bp); end
        n_cmp++;
        if (us != 0) begin n_bad++; $display("FAIL lb_mosi_stable got=%0d exp=0", us); end
        n_cmp++;
        if (cb != 0) begin n_bad++; $display("FAIL lb_cs_low got=%0d exp=0", cb); end
        n_cmp++;
        if (dc != 4851) begin n_bad++; $display("FAIL lb_done_cycle got=%0d exp=4851", dc); end
        n_cmp++;
        if (bits !== tx) begin n_bad++; $display("FAIL lb_bits got=%h exp=%h", bits, tx); end
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_data;
        n_cmp++;
        if (rx_data !== ex) begin n_bad++; $display("FAIL lb_rx got=%h exp=%h", rx_data, ex); end
        n_cmp++;
        if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL lb_cs_end got=%b exp=1", spi_cs_n); end
        step();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL lb_done_width got=%b exp=0", done); end
        g = 1;
        while (busy === 1'b1 && g < 400) begin
            g++;
            step();
        end
        n_cmp++;
        if (g != GAP) begin n_bad++; $display("FAIL lb_gap got=%0d exp=%0d", g, GAP); end
    endtask

    task automatic test_ignore_start;
        int r, fr, lf, bp, us, cb, dc, lowc;
        logic [FB-1:0] bits, tx, ex;
        tx = 48'h3C3C_5A5A_9696;
        miso_sel = 2'd0;
        tx_data = tx;
        exp_q.push_back(tx);
        start = 1'b1;
        step();
        start = 1'b0;
        frame_watch(1'b1, 1'b1, r, fr, lf, bp, us, cb, dc, bits);
        n_cmp++;
        if (bits !== tx) begin n_bad++; $display("FAIL ign_bits got=%h exp=%h", bits, tx); end
        n_cmp++;
        if (dc != 4851) begin n_bad++; $display("FAIL ign_done_cycle got=%0d exp=4851", dc); end
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_data;
        n_cmp++;
        if (rx_data !== ex) begin n_bad++; $display("FAIL ign_rx got=%h exp=%h", rx_data, ex); end
        lowc = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!spi_cs_n || done) lowc++;
        end
        n_cmp++;
        if (lowc != 0) begin n_bad++; $display("FAIL ign_no_second got=%0d exp=0", lowc); end
    endtask

    task automatic test_back_to_back;
        int r, fr, lf, bp, us, cb, dc, h;
        logic [FB-1:0] bits, ex;
        miso_sel = 2'd1;
        tx_data = 48'h0F0F_0000_F0F0;
        exp_q.push_back('1);
        exp_q.push_back('1);
        start = 1'b1;
        step();
        frame_watch(1'b0, 1'b0, r, fr, lf, bp, us, cb, dc, bits);
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_data;
        n_cmp++;
        if (rx_data !== ex) begin n_bad++; $display("FAIL b2b_rx1 got=%h exp=%h", rx_data, ex); end
        h = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (spi_cs_n) h++;
            else break;
        end
        n_cmp++;
        if (h != GAP + 1) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=%0d", h, GAP + 1); end
        frame_watch(1'b0, 1'b0, r, fr, lf, bp, us, cb, dc, bits);
        n_cmp++;
        if (dc != 4851) begin n_bad++; $display("FAIL b2b_done_cycle got=%0d exp=4851", dc); end
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_data;
        n_cmp++;
        if (rx_data !== ex) begin n_bad++; $display("FAIL b2b_rx2 got=%h exp=%h", rx_data, ex); end
        start = 1'b0;
        for (int i = 0; i < 400 && busy; i++) step();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_slave;
        int r, fr, lf, bp, us, cb, dc;
        logic [FB-1:0] bits, tx, ex;
        tx = 48'h0123_4567_89AB;
        slv_init = 48'hDEAD_BEEF_0BAD;
        slv_ld = 1'b1;
        #1;
        slv_ld = 1'b0;
        miso_sel = 2'd2;
        tx_data = tx;
        exp_q.push_back(slv_init);
        start = 1'b1;
        step();
        start = 1'b0;
        frame_watch(1'b0, 1'b0, r, fr, lf, bp, us, cb, dc, bits);
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_data;
        n_cmp++;
        if (rx_data !== ex) begin n_bad++; $display("FAIL slv_rx got=%h exp=%h", rx_data, ex); end
        n_cmp++;
        if (slv !== tx) begin n_bad++; $display("FAIL slv_regout got=%h exp=%h", slv, tx); end
        for (int i = 0; i < 200 && busy; i++) step();
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_loopback();
        test_ignore_start();
        test_back_to_back();
        test_slave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
